// File: rtl/ssd_display_driver.sv
// Seven-segment display driver for the 13-bit debug value.
// A sequential double-dabble converter, doing one iteration per cycle, turns the
// value into 4 BCD digits. The digits are time-multiplexed onto a common-anode
// 4-digit display, with optional blanking of leading zeros.
module ssd_display_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] value,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic [15:0] bcd,
    output logic        busy
);

    localparam int unsigned      CntW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0]  CntMax = CntW'(REFRESH_DIV - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e          state_q, state_d;
    logic [12:0]     captured_q, captured_d;
    // {bcd nibbles [28:13], binary remainder [12:0]}
    logic [28:0]     shreg_q, shreg_d;
    logic [3:0]      iter_q, iter_d;
    logic            busy_q, busy_d;
    logic            pending_q, pending_d;
    logic [15:0]     bcd_q, bcd_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      anode_q, anode_d;
    logic [6:0]      seg_q, seg_d;

    logic [28:0]     adj;
    logic [28:0]     shifted;
    logic            cnt_wrap;
    logic [3:0]      nib;
    logic            blank;

    // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Conversion FSM: capture a new value, then 13 add-3/shift iterations
    always_comb begin
        state_d    = state_q;
        captured_d = captured_q;
        shreg_d    = shreg_q;
        iter_d     = iter_q;
        busy_d     = busy_q;
        pending_d  = pending_q;
        bcd_d      = bcd_q;

        adj = shreg_q;
        for (int k = 0; k < 4; k++) begin
            if (shreg_q[13 + 4*k +: 4] >= 4'd5) begin
                adj[13 + 4*k +: 4] = shreg_q[13 + 4*k +: 4] + 4'd3;
            end
        end
        shifted = adj << 1;

        case (state_q)
            StIdle: begin
                if (pending_q || (value != captured_q)) begin
                    captured_d = value;
                    shreg_d    = {16'h0000, value};
                    iter_d     = 4'd0;
                    busy_d     = 1'b1;
                    pending_d  = 1'b0;
                    state_d    = StShift;
                end
            end
            StShift: begin
                shreg_d = shifted;
                iter_d  = iter_q + 4'd1;
                if (iter_q == 4'd12) begin
                    bcd_d   = shifted[28:13];
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Free-running refresh counter; digit index advances on each wrap
    always_comb begin
        cnt_wrap = (cnt_q == CntMax);
        cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d    = cnt_wrap ? idx_q + 2'd1 : idx_q;
    end

    // Display outputs for the current digit, including leading-zero blanking
    always_comb begin
        nib   = bcd_q[{idx_q, 2'b00} +: 4];
        blank = 1'b0;
        if (BLANK_LZ && (idx_q != 2'd0)) begin
            blank = ((bcd_q >> {idx_q, 2'b00}) == 16'h0000);
        end
        anode_d = blank ? 4'b1111 : ~(4'b0001 << idx_q);
        seg_d   = blank ? 7'b1111111 : decode(nib);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            captured_q <= '0;
            shreg_q    <= '0;
            iter_q     <= '0;
            busy_q     <= 1'b0;
            pending_q  <= 1'b1;
            bcd_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            anode_q    <= 4'b1111;
            seg_q      <= 7'b1111111;
        end else begin
            state_q    <= state_d;
            captured_q <= captured_d;
            shreg_q    <= shreg_d;
            iter_q     <= iter_d;
            busy_q     <= busy_d;
            pending_q  <= pending_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            anode_q    <= anode_d;
            seg_q      <= seg_d;
        end
    end

    assign anode = anode_q;
    assign seg   = seg_q;
    assign bcd   = bcd_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_ssd_display_driver.sv
// Self-checking bench for ssd_display_driver with a 4-cycle refresh divider.
module tb_ssd_display_driver;

    localparam int unsigned RefreshDiv = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] value;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic [15:0] bcd;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] last_bcd;

    localparam logic [6:0] SEG_TAB [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef struct {
        int          v;
        logic [15:0] exp_bcd;
    } vec_t;

    vec_t vecs [6];

    ssd_display_driver #(
        .REFRESH_DIV (RefreshDiv),
        .BLANK_LZ    (1'b1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .anode (anode),
        .seg   (seg),
        .bcd   (bcd),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Present a new value in IDLE and check the exact conversion latency
    task automatic convert(input int v, input logic [15:0] exp, input string tag);
        value = 13'(v);
        tick();
        check({tag, " busy on capture"}, 32'(busy), 32'd1);
        repeat (12) tick();
        check({tag, " busy before done"}, 32'(busy), 32'd1);
        check({tag, " bcd held"}, 32'(bcd), 32'(last_bcd));
        tick();
        check({tag, " busy done"}, 32'(busy), 32'd0);
        check({tag, " bcd"}, 32'(bcd), 32'(exp));
        last_bcd = exp;
    endtask

    // Over one full 16-cycle scan, every visible digit must appear 4 times with
    // its decoded pattern, and blanked slots must be fully dark.
    task automatic check_display(input int v, input string tag);
        int digit [4];
        int hits  [4];
        int div   [4];
        int dark;
        int top;
        int p;
        div  = '{1, 10, 100, 1000};
        dark = 0;
        top  = 0;
        for (int i = 0; i < 4; i++) begin
            digit[i] = (v / div[i]) % 10;
            hits[i]  = 0;
            if (digit[i] != 0) top = i;
        end
        for (int t = 0; t < 16; t++) begin
            tick();
            if (anode == 4'b1111) begin
                dark++;
                check({tag, " dark seg"}, 32'(seg), 32'h7f);
            end else begin
                p = -1;
                for (int i = 0; i < 4; i++) begin
                    if (anode == ~(4'b0001 << i)) p = i;
                end
                check({tag, " anode one-hot"}, 32'(p >= 0), 32'd1);
                if (p >= 0) begin
                    hits[p]++;
                    check({tag, " seg"}, 32'(seg), 32'(SEG_TAB[digit[p]]));
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            check({tag, " digit hits"}, 32'(hits[i]), (i <= top) ? 32'd4 : 32'd0);
        end
        check({tag, " dark count"}, 32'(dark), 32'(4 * (3 - top)));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] a [16];
        logic [3:0] prev;
        int         n_chg;
        int         v;
        int         prev_v;

        vecs[0] = '{8191, 16'h8191};
        vecs[1] = '{7,    16'h0007};
        vecs[2] = '{0,    16'h0000};
        vecs[3] = '{1000, 16'h1000};
        vecs[4] = '{90,   16'h0090};
        vecs[5] = '{1111, 16'h1111};

        // Reset, then the pending flag forces a conversion of 1234
        rst      = 1'b1;
        value    = 13'd1234;
        last_bcd = 16'h0000;
        tick();
        tick();
        check("reset anode", 32'(anode), 32'hf);
        check("reset seg", 32'(seg), 32'h7f);
        check("reset bcd", 32'(bcd), 32'h0);
        check("reset busy", 32'(busy), 32'd0);
        rst = 1'b0;
        convert(1234, 16'h1234, "post-reset 1234");
        check_display(1234, "disp 1234");

        // Table-driven conversions, including blanking cases
        foreach (vecs[i]) begin
            convert(vecs[i].v, vecs[i].exp_bcd, $sformatf("vec %0d", vecs[i].v));
            check_display(vecs[i].v, $sformatf("disp %0d", vecs[i].v));
        end

        // Steady 1111: rotation order, 16-cycle period, no spurious conversion
        prev  = anode;
        n_chg = 0;
        for (int t = 0; t < 16; t++) begin
            tick();
            a[t] = anode;
            if (a[t] != prev) begin
                n_chg++;
                check("scan rotate", 32'(a[t]), 32'({prev[2:0], prev[3]}));
            end
            prev = a[t];
        end
        check("scan changes", 32'(n_chg), 32'd4);
        for (int t = 0; t < 16; t++) begin
            tick();
            check("scan period", 32'(anode), 32'(a[t]));
            check("idle busy", 32'(busy), 32'd0);
        end

        // Value change during SHIFT is deferred until the first conversion ends
        value = 13'd1234;
        tick();
        repeat (5) tick();
        value = 13'd5678;
        repeat (7) tick();
        check("chg bcd first", 32'(bcd), 32'h1111);
        tick();
        check("chg bcd 1234", 32'(bcd), 32'h1234);
        check("chg busy gap", 32'(busy), 32'd0);
        tick();
        check("chg busy restart", 32'(busy), 32'd1);
        check("chg bcd held", 32'(bcd), 32'h1234);
        repeat (12) tick();
        check("chg bcd mid", 32'(bcd), 32'h1234);
        tick();
        check("chg bcd 5678", 32'(bcd), 32'h5678);
        check("chg busy end", 32'(busy), 32'd0);
        last_bcd = 16'h5678;

        // Reset in the middle of a conversion of 4321
        value = 13'd4321;
        tick();
        repeat (6) tick();
        rst = 1'b1;
        tick();
        check("midrst anode", 32'(anode), 32'hf);
        check("midrst seg", 32'(seg), 32'h7f);
        check("midrst bcd", 32'(bcd), 32'h0);
        check("midrst busy", 32'(busy), 32'd0);
        rst      = 1'b0;
        last_bcd = 16'h0000;
        convert(4321, 16'h4321, "post-midrst 4321");
        check_display(4321, "disp 4321");

        // Random values against the arithmetic reference
        prev_v = 4321;
        for (int r = 0; r < 10; r++) begin
            v = int'($urandom_range(0, 8191));
            if (v == prev_v) v = (v + 1) % 8192;
            convert(v, to_bcd(v), $sformatf("rand %0d", v));
            check_display(v, $sformatf("rdisp %0d", v));
            prev_v = v;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
